// File: rtl/buzz_round_ctrl_if.sv
// Buzzer round bus: groups the game-side controls (start, buttons, switches,
// judgement) and the round status returned by the sequencer.
//   start          1  begin a round (pulse)
//   btn            4  debounced buttons, bit i = player i+1
//   sw            32  switch bytes, sw[8i+7:8i] = player i+1
//   judge_valid    1  judgement pulse
//   judge_correct  1  judgement value, 1 = correct
//   busy           1  round in progress
//   buzz_valid     1  a winner is held
//   winner         2  current or last winner
//   answer_valid   1  winner's answer is awaiting judgement
//   answer         8  latched answer byte
//   lockout        4  players locked out this round
//   round_done     1  round resolved (pulse)
//   round_result   2  00 none, 01 correct, 10 no buzz, 11 all locked out
// modport master: the driver of the round (game logic / buttons).
// modport slave:  the sequencer.
interface buzz_round_ctrl_if;
    logic        start;
    logic [3:0]  btn;
    logic [31:0] sw;
    logic        judge_valid;
    logic        judge_correct;
    logic        busy;
    logic        buzz_valid;
    logic [1:0]  winner;
    logic        answer_valid;
    logic [7:0]  answer;
    logic [3:0]  lockout;
    logic        round_done;
    logic [1:0]  round_result;

    modport master (
        output start, btn, sw, judge_valid, judge_correct,
        input  busy, buzz_valid, winner, answer_valid, answer,
               lockout, round_done, round_result
    );

    modport slave (
        input  start, btn, sw, judge_valid, judge_correct,
        output busy, buzz_valid, winner, answer_valid, answer,
               lockout, round_done, round_result
    );
endinterface

// File: rtl/buzz_round_ctrl.sv
// Round sequencer for the four-player buzzer stage. Arms the buzzers, captures
// the first rising press (round-robin on same-cycle ties), collects the
// winner's switch byte, waits for the judgement and locks out wrong answerers
// until the round resolves.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  buzz_round_ctrl_if.slave (all outputs registered)
module buzz_round_ctrl #(
    parameter int unsigned BUZZ_CYCLES   = 500_000_000,
    parameter int unsigned ANSWER_CYCLES = 250_000_000
) (
    input  logic              clk,
    input  logic              rst,
    buzz_round_ctrl_if.slave  bus
);

    localparam int unsigned TW = 32;
    localparam int unsigned NP = 4;
    localparam logic [TW-1:0] BUZZ_LOAD   = TW'(BUZZ_CYCLES - 1);
    localparam logic [TW-1:0] ANSWER_LOAD = TW'(ANSWER_CYCLES - 1);

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_CORRECT = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;
    localparam logic [1:0] RES_ALLOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_ANSWER,
        S_JUDGE,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [TW-1:0]  timer_q;
    logic [1:0]     rr_ptr_q;
    logic [NP-1:0]  btn_q;
    logic           busy_q;
    logic           buzz_valid_q;
    logic [1:0]     winner_q;
    logic           answer_valid_q;
    logic [7:0]     answer_q;
    logic [NP-1:0]  lockout_q;
    logic           round_done_q;
    logic [1:0]     round_result_q;

    logic [NP-1:0]  rise_c;
    logic [NP-1:0]  eligible_c;
    logic [1:0]     pick_c;
    logic           submit_c;
    logic [7:0]     sw_byte_c;
    logic [NP-1:0]  wrong_lock_c;
    logic           wrong_c;

    assign rise_c       = bus.btn & ~btn_q;
    assign eligible_c   = rise_c & ~lockout_q;
    assign submit_c     = rise_c[winner_q];
    assign sw_byte_c    = bus.sw[{winner_q, 3'b000} +: 8];
    assign wrong_lock_c = lockout_q | (NP'(1) << winner_q);

    // Wrong answer: answer window expired, or judged incorrect.
    assign wrong_c = ((state_q == S_ANSWER) && !submit_c && (timer_q == '0)) ||
                     ((state_q == S_JUDGE) && bus.judge_valid && !bus.judge_correct);

    // Round-robin pick: scan downward so the closest eligible player to
    // rr_ptr is the last (winning) assignment.
    always_comb begin
        pick_c = rr_ptr_q;
        for (int k = NP - 1; k >= 0; k--) begin
            if (eligible_c[rr_ptr_q + 2'(k)]) begin
                pick_c = rr_ptr_q + 2'(k);
            end
        end
    end

    // Round FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            rr_ptr_q       <= '0;
            btn_q          <= '0;
            busy_q         <= 1'b0;
            buzz_valid_q   <= 1'b0;
            winner_q       <= '0;
            answer_valid_q <= 1'b0;
            answer_q       <= '0;
            lockout_q      <= '0;
            round_done_q   <= 1'b0;
            round_result_q <= RES_NONE;
        end else begin
            btn_q        <= bus.btn;
            round_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q        <= S_ARMED;
                        busy_q         <= 1'b1;
                        lockout_q      <= '0;
                        round_result_q <= RES_NONE;
                        timer_q        <= BUZZ_LOAD;
                    end
                end

                S_ARMED: begin
                    if (|eligible_c) begin
                        state_q      <= S_ANSWER;
                        winner_q     <= pick_c;
                        rr_ptr_q     <= pick_c + 2'd1;
                        buzz_valid_q <= 1'b1;
                        timer_q      <= ANSWER_LOAD;
                    end else if (timer_q == '0) begin
                        state_q        <= S_DONE;
                        round_result_q <= RES_TIMEOUT;
                        round_done_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                S_ANSWER: begin
                    if (submit_c) begin
                        state_q        <= S_JUDGE;
                        answer_q       <= sw_byte_c;
                        answer_valid_q <= 1'b1;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                S_JUDGE: begin
                    if (bus.judge_valid && bus.judge_correct) begin
                        state_q        <= S_DONE;
                        round_result_q <= RES_CORRECT;
                        round_done_q   <= 1'b1;
                        buzz_valid_q   <= 1'b0;
                        answer_valid_q <= 1'b0;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Shared wrong-answer handling for ANSWER timeout and JUDGE.
            if (wrong_c) begin
                lockout_q      <= wrong_lock_c;
                buzz_valid_q   <= 1'b0;
                answer_valid_q <= 1'b0;
                if (wrong_lock_c == '1) begin
                    state_q        <= S_DONE;
                    round_result_q <= RES_ALLOUT;
                    round_done_q   <= 1'b1;
                    timer_q        <= '0;
                end else begin
                    state_q <= S_ARMED;
                    timer_q <= BUZZ_LOAD;
                end
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.buzz_valid   = buzz_valid_q;
    assign bus.winner       = winner_q;
    assign bus.answer_valid = answer_valid_q;
    assign bus.answer       = answer_q;
    assign bus.lockout      = lockout_q;
    assign bus.round_done   = round_done_q;
    assign bus.round_result = round_result_q;

endmodule

// File: tb/tb_buzz_round_ctrl.sv
// Bench for buzz_round_ctrl with BUZZ_CYCLES=20, ANSWER_CYCLES=10: directed
// scenarios plus randomized rounds checked against a transaction-level model.
module tb_buzz_round_ctrl;

    localparam int BUZZ = 20;
    localparam int ANS  = 10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Transaction-level model state.
    int         m_rr;
    logic [3:0] m_lock;

    buzz_round_ctrl_if bus ();

    buzz_round_ctrl #(
        .BUZZ_CYCLES   (BUZZ),
        .ANSWER_CYCLES (ANS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int model_pick(input logic [3:0] elig, input int rr);
        for (int k = 0; k < 4; k++) begin
            if (elig[(rr + k) % 4]) return (rr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [19:0] out_vec();
        return {bus.busy, bus.buzz_valid, bus.winner, bus.answer_valid, bus.answer,
                bus.lockout, bus.round_done, bus.round_result};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.btn = '0; bus.sw = '0;
        bus.judge_valid = 1'b0; bus.judge_correct = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_vec() !== 20'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=00000", out_vec()); end
    endtask

    task automatic test_basic();
        do_reset();
        pulse_start();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
        // judge_valid outside JUDGE is ignored
        bus.judge_valid = 1'b1; bus.judge_correct = 1'b1;
        tick();
        bus.judge_valid = 1'b0;
        total++; if ({bus.round_done, bus.buzz_valid, bus.busy} !== 3'b001) begin bad++; $display("FAIL basic_judge_ignored got=%b exp=001", {bus.round_done, bus.buzz_valid, bus.busy}); end
        bus.btn = 4'b0100;
        tick();
        total++; if ({bus.buzz_valid, bus.winner} !== 3'b110) begin bad++; $display("FAIL basic_winner got=%b exp=110", {bus.buzz_valid, bus.winner}); end
        bus.btn = 4'b0000;
        // start outside IDLE is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.sw = 32'h00A5_0000;
        bus.btn = 4'b0100;
        tick();
        bus.btn = 4'b0000;
        total++; if ({bus.answer_valid, bus.answer} !== 9'h1A5) begin bad++; $display("FAIL basic_answer got=%h exp=1a5", {bus.answer_valid, bus.answer}); end
        tick();
        bus.judge_valid = 1'b1; bus.judge_correct = 1'b1;
        tick();
        bus.judge_valid = 1'b0;
        total++; if ({bus.round_done, bus.round_result, bus.lockout, bus.busy} !== 8'b1_01_0000_1) begin bad++; $display("FAIL basic_done got=%b exp=10100001", {bus.round_done, bus.round_result, bus.lockout, bus.busy}); end
        tick();
        total++; if ({bus.round_done, bus.busy, bus.round_result} !== 4'b0001) begin bad++; $display("FAIL basic_idle got=%b exp=0001", {bus.round_done, bus.busy, bus.round_result}); end
    endtask

    task automatic finish_correct(input logic [3:0] submit_mask);
        bus.btn = 4'b0000; tick();
        bus.btn = submit_mask; tick();
        bus.btn = 4'b0000;
        bus.judge_valid = 1'b1; bus.judge_correct = 1'b1; tick();
        bus.judge_valid = 1'b0; tick();
    endtask

    task automatic test_tiebreak();
        do_reset();
        pulse_start();
        bus.btn = 4'b1010; tick();
        total++; if (bus.winner !== 2'd1) begin bad++; $display("FAIL tie_first got=%0d exp=1", bus.winner); end
        finish_correct(4'b0010);
        pulse_start();
        bus.btn = 4'b1010; tick();
        total++; if (bus.winner !== 2'd3) begin bad++; $display("FAIL tie_second got=%0d exp=3", bus.winner); end
        finish_correct(4'b1000);
    endtask

    task automatic test_lockout_chain();
        logic [3:0] exp_lock;
        do_reset();
        pulse_start();
        exp_lock = 4'b0000;
        for (int p = 0; p < 4; p++) begin
            bus.btn = 4'(1 << p); tick();
            total++; if ({bus.buzz_valid, bus.winner} !== {1'b1, 2'(p)}) begin bad++; $display("FAIL chain_winner%0d got=%b", p, {bus.buzz_valid, bus.winner}); end
            bus.btn = 4'b0000; tick();
            bus.btn = 4'(1 << p); tick();
            bus.btn = 4'b0000;
            bus.judge_valid = 1'b1; bus.judge_correct = 1'b0; tick();
            bus.judge_valid = 1'b0;
            exp_lock[p] = 1'b1;
            total++; if (bus.lockout !== exp_lock) begin bad++; $display("FAIL chain_lock%0d got=%b exp=%b", p, bus.lockout, exp_lock); end
            if (p < 3) begin
                total++; if ({bus.round_done, bus.buzz_valid, bus.busy} !== 3'b001) begin bad++; $display("FAIL chain_rearm%0d got=%b exp=001", p, {bus.round_done, bus.buzz_valid, bus.busy}); end
                if (p == 0) begin
                    bus.btn = 4'b0001; tick();
                    total++; if (bus.buzz_valid !== 1'b0) begin bad++; $display("FAIL chain_locked_press got=%b exp=0", bus.buzz_valid); end
                    bus.btn = 4'b0000; tick();
                end
            end
        end
        total++; if ({bus.round_done, bus.round_result} !== 3'b111) begin bad++; $display("FAIL chain_allout got=%b exp=111", {bus.round_done, bus.round_result}); end
        tick();
        total++; if ({bus.round_done, bus.busy} !== 2'b00) begin bad++; $display("FAIL chain_single_pulse got=%b exp=00", {bus.round_done, bus.busy}); end
    endtask

    task automatic test_timeouts();
        int cnt;
        do_reset();
        pulse_start();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(); cnt++;
            if (bus.round_done) break;
        end
        total++; if (cnt !== BUZZ) begin bad++; $display("FAIL tmo_buzz_cycles got=%0d exp=%0d", cnt, BUZZ); end
        total++; if (bus.round_result !== 2'b10) begin bad++; $display("FAIL tmo_buzz_result got=%b exp=10", bus.round_result); end
        tick();
        pulse_start();
        bus.btn = 4'b0100; tick();
        bus.btn = 4'b0000;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(); cnt++;
            if (bus.lockout[2]) break;
        end
        total++; if (cnt !== ANS) begin bad++; $display("FAIL tmo_answer_cycles got=%0d exp=%0d", cnt, ANS); end
        total++; if ({bus.buzz_valid, bus.busy, bus.round_done} !== 3'b010) begin bad++; $display("FAIL tmo_answer_rearm got=%b exp=010", {bus.buzz_valid, bus.busy, bus.round_done}); end
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(); cnt++;
            if (bus.round_done) break;
        end
        total++; if (cnt !== BUZZ) begin bad++; $display("FAIL tmo_rearm_cycles got=%0d exp=%0d", cnt, BUZZ); end
        total++; if ({bus.round_result, bus.lockout} !== 6'b10_0100) begin bad++; $display("FAIL tmo_rearm_result got=%b exp=100100", {bus.round_result, bus.lockout}); end
        tick();
    endtask

    task automatic test_held_and_reset();
        int dones;
        do_reset();
        bus.btn = 4'b0001; tick();
        pulse_start();
        tick(); tick(); tick();
        total++; if ({bus.buzz_valid, bus.busy} !== 2'b01) begin bad++; $display("FAIL held_no_buzz got=%b exp=01", {bus.buzz_valid, bus.busy}); end
        bus.btn = 4'b0000; tick();
        bus.btn = 4'b0001; tick();
        total++; if ({bus.buzz_valid, bus.winner} !== 3'b100) begin bad++; $display("FAIL held_repress got=%b exp=100", {bus.buzz_valid, bus.winner}); end
        bus.btn = 4'b0000; tick();
        bus.sw = 32'h0000_003C;
        bus.btn = 4'b0001; tick();
        bus.btn = 4'b0000;
        total++; if ({bus.answer_valid, bus.answer} !== 9'h13C) begin bad++; $display("FAIL held_answer got=%h exp=13c", {bus.answer_valid, bus.answer}); end
        // asynchronous reset in the middle of JUDGE
        rst = 1'b1;
        #1;
        total++; if (out_vec() !== 20'h0) begin bad++; $display("FAIL rst_async got=%h exp=00000", out_vec()); end
        #2;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.round_done) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
        pulse_start();
        bus.btn = 4'b0010; tick();
        total++; if ({bus.busy, bus.buzz_valid, bus.winner} !== 4'b1101) begin bad++; $display("FAIL rst_restart got=%b exp=1101", {bus.busy, bus.buzz_valid, bus.winner}); end
        finish_correct(4'b0010);
    endtask

    task automatic test_random();
        logic [3:0]  mask;
        logic [31:0] swv;
        logic [7:0]  exp_ans;
        int          w;
        int          p;
        bit          corr;
        bit          done;
        do_reset();
        m_rr = 0;
        for (int r = 0; r < 12; r++) begin
            m_lock = 4'b0000;
            pulse_start();
            done = 0;
            while (!done) begin
                repeat ($urandom_range(0, 3)) tick();
                mask = 4'($urandom_range(1, 15));
                if ((mask & ~m_lock) == 4'b0000) begin
                    do p = $urandom_range(0, 3); while (m_lock[p]);
                    mask[p] = 1'b1;
                end
                w = model_pick(mask & ~m_lock, m_rr);
                m_rr = (w + 1) % 4;
                bus.btn = mask; tick();
                total++; if ({bus.buzz_valid, bus.winner} !== {1'b1, 2'(w)}) begin bad++; $display("FAIL rand_winner r=%0d got=%b exp=%0d mask=%b lock=%b", r, {bus.buzz_valid, bus.winner}, w, mask, m_lock); end
                bus.btn = 4'b0000; tick();
                repeat ($urandom_range(0, 3)) tick();
                swv = $urandom;
                exp_ans = 8'((swv >> (8 * w)) & 32'hFF);
                bus.sw = swv;
                bus.btn = 4'($urandom_range(0, 15)) | 4'(1 << w);
                tick();
                bus.btn = 4'b0000;
                total++; if ({bus.answer_valid, bus.answer} !== {1'b1, exp_ans}) begin bad++; $display("FAIL rand_answer r=%0d got=%h exp=%h", r, {bus.answer_valid, bus.answer}, {1'b1, exp_ans}); end
                repeat ($urandom_range(0, 3)) tick();
                corr = ($urandom_range(0, 2) == 0);
                bus.judge_valid = 1'b1; bus.judge_correct = corr; tick();
                bus.judge_valid = 1'b0;
                if (corr) begin
                    total++; if ({bus.round_done, bus.round_result, bus.lockout} !== {3'b101, m_lock}) begin bad++; $display("FAIL rand_correct r=%0d got=%b exp=%b", r, {bus.round_done, bus.round_result, bus.lockout}, {3'b101, m_lock}); end
                    done = 1;
                end else begin
                    m_lock[w] = 1'b1;
                    if (m_lock == 4'b1111) begin
                        total++; if ({bus.round_done, bus.round_result, bus.lockout} !== 7'b111_1111) begin bad++; $display("FAIL rand_allout r=%0d got=%b exp=1111111", r, {bus.round_done, bus.round_result, bus.lockout}); end
                        done = 1;
                    end else begin
                        total++; if ({bus.round_done, bus.buzz_valid, bus.lockout} !== {2'b00, m_lock}) begin bad++; $display("FAIL rand_wrong r=%0d got=%b exp=%b", r, {bus.round_done, bus.buzz_valid, bus.lockout}, {2'b00, m_lock}); end
                    end
                end
            end
            tick();
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rand_idle r=%0d got=%b exp=0", r, bus.busy); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start = 1'b0; bus.btn = '0; bus.sw = '0;
        bus.judge_valid = 1'b0; bus.judge_correct = 1'b0;
        test_reset();
        test_basic();
        test_tiebreak();
        test_lockout_chain();
        test_timeouts();
        test_held_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buzz_round_ctrl.md
# buzz_round_ctrl

Round sequencer for the four-player buzzer stage. It arms the buzzers and captures the first player to press, breaking same-cycle ties round-robin. It then collects that player's 8-bit switch answer, waits for the game logic to judge it, and locks out wrong answerers until the round resolves. It sits between the per-player debounced buttons and switch buses and the game-logic CPU, replacing the free-running first-press latch.

## Interface
Parameters:
- BUZZ_CYCLES, 500_000_000: maximum cycles in ARMED before the round ends with no buzz (≥1).
- ANSWER_CYCLES, 250_000_000: maximum cycles the winner has to submit an answer (≥1).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a round; honored only in IDLE.
- btn  in  4  debounced buttons, active-high; bit i = player i+1.
- sw  in  32  switch bytes; sw[8i+7:8i] = player i+1.
- judge_valid  in  1  one-cycle pulse; judgement available; honored only in JUDGE.
- judge_correct  in  1  qualified by judge_valid; 1 = correct.
- busy  out  1  high in every state except IDLE.
- buzz_valid  out  1  a winner is held (ANSWER or JUDGE).
- winner  out  2  current or last winner, 0..3.
- answer_valid  out  1  high in JUDGE.
- answer  out  8  latched switch byte of the winner.
- lockout  out  4  players locked out this round.
- round_done  out  1  one-cycle pulse when the round resolves.
- round_result  out  2  00 none, 01 correct, 10 no buzz / buzz timeout, 11 all locked out.

## Operation
- States: IDLE, ARMED, ANSWER, JUDGE, DONE.
- Edge detect: btn_q <= btn every cycle in every state. rise = btn & ~btn_q. A button already held when a round starts does not count until it is released and pressed again.
- IDLE → ARMED on start:
  - clear lockout and round_result;
  - load the timer with BUZZ_CYCLES-1.
  - winner and answer keep their previous values.
- ARMED:
  - eligible = rise & ~lockout.
  - If any bit is eligible: pick the winner by round-robin starting at rr_ptr, update rr_ptr <= winner+1 (mod 4), go to ANSWER, load the timer with ANSWER_CYCLES-1.
  - Else if timer == 0: round_result <= 10, go to DONE.
  - Else the timer decrements.
- ANSWER:
  - rise[winner] → answer <= winner's sw byte sampled on that edge; go to JUDGE. Other buttons are ignored.
  - Else if timer == 0: treat as a wrong answer (see below).
- JUDGE:
  - Wait with no timeout for judge_valid.
  - correct → round_result <= 01, go to DONE.
  - wrong → wrong-answer rule.
- Wrong-answer rule:
  - lockout[winner] <= 1.
  - If the new lockout is 4'b1111: round_result <= 11, go to DONE.
  - Otherwise go to ARMED and reload the timer with BUZZ_CYCLES-1.
- DONE: round_done = 1 for exactly one cycle, then IDLE.
- rr_ptr resets to 0, so after reset the priority order is player1 > player2 > player3 > player4. rr_ptr persists across rounds.
- Ignored inputs: start outside IDLE; judge_valid outside JUDGE.

## Timing
- Reset values: state IDLE, busy 0, buzz_valid 0, winner 0, answer_valid 0, answer 0, lockout 0, round_done 0, round_result 00, rr_ptr 0, btn_q 0, timer 0.
- rst is asserted asynchronously at any time and returns everything to reset values immediately. No round_done is produced for an aborted round.
- All outputs are registered. busy is high the cycle after start is sampled.
- Buzz latency: btn[i] is first sampled high at edge n. Then buzz_valid and winner are valid after edge n, one cycle.
- Submit latency: answer and answer_valid are valid the cycle after the rising edge of the winner's button is sampled.
- Timeouts:
  - ARMED lasts exactly BUZZ_CYCLES cycles without a buzz before DONE.
  - ANSWER lasts exactly ANSWER_CYCLES cycles.
  - Each re-arm gets a full BUZZ_CYCLES.
- Simultaneous events:
  - A buzz and a timer reaching 0 in the same cycle: the buzz wins.
  - In ANSWER, a submit on the cycle with timer == 0: the submit wins.
- Round outcome fields:
  - round_result holds from DONE until the next start.
  - winner and answer hold until overwritten.
- The exit from JUDGE takes effect on the edge that samples judge_valid.

## Test plan
- Basic round (BUZZ_CYCLES=20, ANSWER_CYCLES=10):
  - Stimulus: start; btn=0100; release; press btn[2] with sw[23:16]=8'hA5; judge_valid with judge_correct=1.
  - Required: winner=2 one cycle after the press; answer=A5 and answer_valid=1; round_done pulse; round_result=01; lockout=0000.
- Tie-break: after reset, start with btn=1010 in the same cycle → winner=1. Finish the round, start again, btn=1010 → winner=3 (rr_ptr=2).
- Lockout chain:
  - Player 1 buzzes and is judged wrong → lockout=0001, back in ARMED.
  - A new press by player 1 is ignored.
  - Players 2, 3, 4 each buzz and are judged wrong → lockout=1111, round_result=11, one round_done pulse.
- Timeouts:
  - No press after start → round_done exactly 20 cycles after ARMED entry, round_result=10.
  - Winner never resubmits → lockout bit set after 10 cycles, then re-arm.
- Held button: btn[0] high before start and kept high → no buzz; release and re-press → winner=0.
- Reset mid-JUDGE: rst pulse → all outputs at reset values the same cycle; no round_done; a subsequent start works normally.
